// File: rtl/pic_pkg.sv
// Shared PIC definitions: opcode constants, fetch-stage defaults and the
// sleep-state encoding used when PIC_FETCH_SLEEP_EN is defined.
package pic_pkg;

    localparam logic [3:0]  OP_CALL  = 4'b1001;
    localparam logic [2:0]  OP_GOTO  = 3'b101;
    localparam logic [3:0]  OP_RETLW = 4'b1000;
    localparam logic [11:0] OP_NOP   = 12'h000;

    localparam int          PIC_PC_WIDTH     = 11;
    localparam logic [10:0] PIC_RESET_VECTOR = 11'h7FF;

    typedef enum logic {
        RUN      = 1'b0,
        SLEEPING = 1'b1
    } sleep_state_t;

endpackage

// File: rtl/pic_fetch_if.sv
// Fetch-stage bus: ROM port, pic_ctrl strobes and the PCL data path.
// The slave modport is the fetch stage; master is pic_ctrl plus the ROM.
// sleep/wake exist only when PIC_FETCH_SLEEP_EN is defined.
interface pic_fetch_if #(
    parameter int PC_WIDTH = pic_pkg::PIC_PC_WIDTH
);
    logic [11:0]         prog_data;
    logic [PC_WIDTH-1:0] prog_addr;
    logic [11:0]         inst;
    logic                pc_load;
    logic                pc_push;
    logic                pc_pop;
    logic                pc_wen;
    logic                pc_oen;
    logic                inst_skip;
    logic                skip_cond;
    logic [7:0]          data_in;
    logic [1:0]          status_pa;
    logic [7:0]          pc_dout;
    logic                flush;
`ifdef PIC_FETCH_SLEEP_EN
    logic                sleep;
    logic                wake;
`endif

    modport slave (
`ifdef PIC_FETCH_SLEEP_EN
        input  sleep, wake,
`endif
        input  prog_data, pc_load, pc_push, pc_pop, pc_wen, pc_oen,
        input  inst_skip, skip_cond, data_in, status_pa,
        output prog_addr, inst, pc_dout, flush
    );

    modport master (
`ifdef PIC_FETCH_SLEEP_EN
        output sleep, wake,
`endif
        output prog_data, pc_load, pc_push, pc_pop, pc_wen, pc_oen,
        output inst_skip, skip_cond, data_in, status_pa,
        input  prog_addr, inst, pc_dout, flush
    );

endinterface

// File: rtl/pic_stack.sv
// Return-address shift stack. Push shifts toward the bottom and drops the
// deepest entry on overflow; pop shifts toward the top and leaves the
// deepest entry in place, so underflow re-reads it. Push wins over pop.
module pic_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top
);

    logic [WIDTH-1:0] r_stk [DEPTH];

    assign o_top = r_stk[0];

    // Shift the entries on push or pop; clear all of them on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
        end else if (i_push) begin
            r_stk[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_stk[i] <= r_stk[i-1];
        end else if (i_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) r_stk[i] <= r_stk[i+1];
        end
    end

endmodule

// File: rtl/pic_fetch.sv
// PIC instruction fetch / program-counter stage.
// Holds PC, return stack and instruction register; inserts a NOP bubble
// after any taken branch, return, PCL write or taken skip.
// Optional build macro: PIC_FETCH_SLEEP_EN adds sleep/wake handling.
module pic_fetch
    import pic_pkg::*;
#(
    parameter int                  PC_WIDTH     = PIC_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(PIC_RESET_VECTOR),
    parameter int                  STACK_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    pic_fetch_if.slave  bus
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [11:0]         r_inst;
    logic                r_flush;
    logic [PC_WIDTH-1:0] w_top;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [10:0]         w_tgt;
    logic                w_bubble;
    logic                w_push;
    logic                w_pop;
    logic                w_run;

`ifdef PIC_FETCH_SLEEP_EN
    sleep_state_t        r_state;
    assign w_run = (r_state == RUN);
`else
    assign w_run = 1'b1;
`endif

    assign w_bubble = bus.pc_load | bus.pc_pop | bus.pc_wen
                    | (bus.inst_skip & bus.skip_cond);
    assign w_push   = w_run & bus.pc_push & bus.pc_load;
    assign w_pop    = w_run & bus.pc_pop & ~w_push;

    assign bus.prog_addr = r_pc;
    assign bus.inst      = r_inst;
    assign bus.flush     = r_flush;
    // PCL reads see the already-incremented PC, i.e. the next instruction.
    assign bus.pc_dout   = bus.pc_oen ? 8'(r_pc) : 8'h00;

    // Next-PC select: branch targets are built at 11 bits, then resized.
    always_comb begin
        w_tgt     = '0;
        w_next_pc = r_pc + 1'b1;
        if (bus.pc_load) begin
            if (r_inst[11:8] == OP_CALL)
                w_tgt = {1'b0, bus.status_pa[0], 1'b0, r_inst[7:0]};
            else
                w_tgt = {1'b0, bus.status_pa[1], r_inst[8:0]};
            w_next_pc = PC_WIDTH'(w_tgt);
        end else if (bus.pc_pop) begin
            w_next_pc = w_top;
        end else if (bus.pc_wen) begin
            w_tgt     = {bus.status_pa, 1'b0, bus.data_in};
            w_next_pc = PC_WIDTH'(w_tgt);
        end
    end

    // Fetch pipeline register and PC update; sleep freezes PC and issues NOPs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_VECTOR;
            r_inst  <= OP_NOP;
            r_flush <= 1'b0;
`ifdef PIC_FETCH_SLEEP_EN
            r_state <= RUN;
`endif
        end else begin
            if (w_run) begin
                r_inst  <= w_bubble ? OP_NOP : bus.prog_data;
                r_flush <= w_bubble;
                r_pc    <= w_next_pc;
            end else begin
                r_inst  <= OP_NOP;
                r_flush <= 1'b0;
            end
`ifdef PIC_FETCH_SLEEP_EN
            if (bus.wake)
                r_state <= RUN;
            else if (bus.sleep)
                r_state <= SLEEPING;
`endif
        end
    end

    pic_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_din  (r_pc),
        .o_top  (w_top)
    );

endmodule

// File: tb/tb_pic_fetch.sv
// Directed bench for pic_fetch (default build, PC_WIDTH=11, depth 2).
module tb_pic_fetch;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    pic_fetch_if #(.PC_WIDTH(11)) bus ();

    pic_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.pc_load   = 1'b0;
        bus.pc_push   = 1'b0;
        bus.pc_pop    = 1'b0;
        bus.pc_wen    = 1'b0;
        bus.inst_skip = 1'b0;
        bus.skip_cond = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        idle();
        bus.pc_oen    = 1'b1;
        bus.prog_data = 12'h000;
        bus.data_in   = 8'h00;
        bus.status_pa = 2'b00;
        #12;
        chk("rst_addr",   bus.prog_addr, 32'h7FF);
        chk("rst_inst",   bus.inst,      32'h000);
        chk("rst_flush",  bus.flush,     32'h0);
        chk("rst_pcdout", bus.pc_dout,   32'hFF);

        // first fetch from reset vector, PC wraps 7FF -> 000
        reset = 1'b0;
        bus.pc_oen = 1'b0;
        bus.prog_data = 12'hC05;
        tick();
        chk("fetch_inst",  bus.inst,      32'hC05);
        chk("fetch_addr",  bus.prog_addr, 32'h000);
        chk("pcdout_off",  bus.pc_dout,   32'h00);

        // GOTO A23 with pa=01
        bus.prog_data = 12'hA23;
        tick();
        chk("goto_prep", bus.prog_addr, 32'h001);
        bus.pc_load = 1'b1; bus.status_pa = 2'b01; bus.prog_data = 12'hFFF;
        tick();
        chk("goto_addr",  bus.prog_addr, 32'h023);
        chk("goto_inst",  bus.inst,      32'h000);
        chk("goto_flush", bus.flush,     32'h1);
        idle(); bus.prog_data = 12'h123;
        tick();
        chk("goto_next_inst",  bus.inst,      32'h123);
        chk("goto_next_flush", bus.flush,     32'h0);
        chk("goto_next_addr",  bus.prog_addr, 32'h024);

        // move to pc=010 via PCL write, then CALL 9F0 from return address 011
        bus.status_pa = 2'b00; bus.pc_wen = 1'b1; bus.data_in = 8'h10; bus.prog_data = 12'hFFF;
        tick();
        chk("wen_addr", bus.prog_addr, 32'h010);
        idle(); bus.prog_data = 12'h9F0;
        tick();
        chk("call_prep", bus.prog_addr, 32'h011);
        bus.pc_load = 1'b1; bus.pc_push = 1'b1;
        tick();
        chk("call_addr",  bus.prog_addr, 32'h0F0);
        chk("call_flush", bus.flush,     32'h1);
        idle(); bus.prog_data = 12'h800;
        tick();
        bus.pc_oen = 1'b1;
        #1;
        chk("pcdout_on", bus.pc_dout, 32'hF1);
        bus.pc_oen = 1'b0;
        bus.pc_pop = 1'b1;
        tick();
        chk("ret_addr",  bus.prog_addr, 32'h011);
        chk("ret_inst",  bus.inst,      32'h000);
        chk("ret_flush", bus.flush,     32'h1);
        idle();

        // three CALLs from 005, 00A, 00F overflow the 2-deep stack
        bus.pc_wen = 1'b1; bus.data_in = 8'h04; tick(); idle();
        bus.prog_data = 12'h901; tick();
        bus.pc_load = 1'b1; bus.pc_push = 1'b1; tick(); idle();
        chk("ovf_call1", bus.prog_addr, 32'h001);
        bus.pc_wen = 1'b1; bus.data_in = 8'h09; tick(); idle();
        bus.prog_data = 12'h902; tick();
        bus.pc_load = 1'b1; bus.pc_push = 1'b1; tick(); idle();
        chk("ovf_call2", bus.prog_addr, 32'h002);
        bus.pc_wen = 1'b1; bus.data_in = 8'h0E; tick(); idle();
        bus.prog_data = 12'h903; tick();
        bus.pc_load = 1'b1; bus.pc_push = 1'b1; tick(); idle();
        chk("ovf_call3", bus.prog_addr, 32'h003);
        bus.prog_data = 12'h000; tick();
        bus.pc_pop = 1'b1; tick(); idle();
        chk("pop1", bus.prog_addr, 32'h00F);
        tick();
        bus.pc_pop = 1'b1; tick(); idle();
        chk("pop2", bus.prog_addr, 32'h00A);
        tick();
        bus.pc_pop = 1'b1; tick(); idle();
        chk("pop3_underflow", bus.prog_addr, 32'h00A);

        // skip taken and not taken
        bus.prog_data = 12'h555; tick();
        chk("pre_skip_inst", bus.inst, 32'h555);
        bus.inst_skip = 1'b1; bus.skip_cond = 1'b1; bus.prog_data = 12'h666;
        tick();
        chk("skip_addr",  bus.prog_addr, 32'h00C);
        chk("skip_inst",  bus.inst,      32'h000);
        chk("skip_flush", bus.flush,     32'h1);
        bus.skip_cond = 1'b0; bus.prog_data = 12'h777;
        tick();
        chk("noskip_addr",  bus.prog_addr, 32'h00D);
        chk("noskip_inst",  bus.inst,      32'h777);
        chk("noskip_flush", bus.flush,     32'h0);
        idle();

        // PCL write with pa=10, then GOTO with pa[1] and inst bit 8 set
        bus.pc_wen = 1'b1; bus.data_in = 8'h3C; bus.status_pa = 2'b10;
        tick(); idle();
        chk("pcl_addr", bus.prog_addr, 32'h43C);
        bus.prog_data = 12'hBFF; tick();
        bus.pc_load = 1'b1; bus.status_pa = 2'b11; tick(); idle();
        chk("goto_hi_addr", bus.prog_addr, 32'h3FF);

        // reset asserted mid-branch discards the load; then 7FF wraps to 000
        bus.prog_data = 12'hA50; tick();
        bus.pc_load = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_addr",  bus.prog_addr, 32'h7FF);
        chk("midrst_inst",  bus.inst,      32'h000);
        chk("midrst_flush", bus.flush,     32'h0);
        tick();
        chk("midrst_hold", bus.prog_addr, 32'h7FF);
        reset = 1'b0; idle(); bus.prog_data = 12'h0AB;
        tick();
        chk("wrap_addr",  bus.prog_addr, 32'h000);
        chk("wrap_inst",  bus.inst,      32'h0AB);
        chk("wrap_flush", bus.flush,     32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pic_fetch.md
Name: pic_fetch

Overview:
- Instruction-fetch and program-counter stage directly upstream of pic_ctrl.
- Holds the PC, the return-address stack and the instruction register.
- Drives the program-ROM address; its registered instruction feeds pic_ctrl's inst input.
- Consumes pic_ctrl's pc_load/pc_push/pc_pop/pc_wen/pc_oen/inst_skip strobes and injects a NOP bubble after every taken branch, return, PCL write or taken skip.

Parameters:
- PC_WIDTH, 11, program-counter and ROM-address width (2K words).
- RESET_VECTOR, 11'h7FF, PC value loaded on reset.
- STACK_DEPTH, 2, number of return-address entries (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- prog_data  input  12  ROM word at prog_addr, combinational read.
- prog_addr  output  PC_WIDTH  current PC, drives the ROM.
- inst  output  12  registered instruction, goes to pic_ctrl.
- pc_load  input  1  GOTO/CALL strobe from pic_ctrl.
- pc_push  input  1  CALL push strobe.
- pc_pop  input  1  RETLW pop strobe.
- pc_wen  input  1  write to PCL from the file data bus.
- pc_oen  input  1  drive PCL onto pc_dout.
- inst_skip  input  1  conditional-skip instruction executing.
- skip_cond  input  1  skip condition (ALU zero/bit-test result).
- data_in  input  8  file data bus, used for PCL writes.
- status_pa  input  2  STATUS page bits [6:5].
- pc_dout  output  8  PC[7:0] when pc_oen is high, else 8'h00.
- flush  output  1  high while the issued inst is a forced NOP bubble.

Behaviour:
- Reset (async, reset=1):
  - pc=RESET_VECTOR, inst=12'h000, all stack entries=0, flush=0.
  - prog_addr follows pc immediately.
- Every rising clk edge, in execute order: inst <= (bubble ? 12'h000 : prog_data); flush <= bubble; pc <= next_pc.
- bubble = pc_load | pc_pop | pc_wen | (inst_skip & skip_cond).
- next_pc priority:
  1. pc_load with inst[11:8]==4'b1001 (CALL): {status_pa[0], 1'b0, inst[7:0]}.
  2. pc_load otherwise (GOTO): {status_pa[1], inst[8:0]}.
  3. pc_pop: stack[0].
  4. pc_wen: {status_pa, 1'b0, data_in[7:0]}.
  5. Otherwise: pc+1, wrapping modulo 2^PC_WIDTH (7FF to 000).
  - For PC_WIDTH other than 11, upper bits are zero-filled or truncated.
- Stack (PIC shift semantics):
  - Push (pc_push & pc_load): stack[i] <= stack[i-1]; stack[0] <= pc, which is already the return address.
  - Overflow: the deepest entry is silently lost.
  - Pop: stack[i] <= stack[i+1]; the deepest entry keeps its value (underflow re-reads it).
  - pc_push without pc_load is ignored.
  - pc_push with pc_pop: the pop is ignored and push wins.
- Skip: when inst_skip & skip_cond, pc still increments; the prefetched word is replaced by a NOP. Without skip_cond there is no bubble.
- Bubble cycle: inst=0, so pic_ctrl strobes are all low; back-to-back bubbles cannot occur.
- pc_dout reflects the PC of the next instruction, matching PIC PCL-read semantics.
- Reset asserted mid-branch discards the pending load/pop and the bubble.

Optional Feature:
- Macro: PIC_FETCH_SLEEP_EN.
- When defined, adds ports sleep (input 1, pic_ctrl SLEEP decode) and wake (input 1, WDT/reset-pin event).
  - sleep enters state SLEEPING: pc and stack hold; inst is forced to 12'h000.
  - wake returns to RUN, with pc resuming at its held value.
  - sleep and wake in the same cycle: wake wins.
  - Reset state is RUN.
- When undefined, the ports are absent and the state machine is removed; the block is always RUN.

Decomposition:
- Shared package pic_pkg holds:
  - opcode constants (CALL 4'b1001, GOTO 3'b101, RETLW 4'b1000, NOP 12'h000);
  - PIC_PC_WIDTH and PIC_RESET_VECTOR defaults;
  - the sleep-state enum (RUN, SLEEPING).
- One natural sub-module: pic_stack, a parameterised STACK_DEPTH shift stack with push, pop and top ports.

Test Plan:
- Reset release: prog_addr=7FF, inst=000. One clock with prog_data=C05 gives inst=C05 and prog_addr=000.
- GOTO: inst=A23, status_pa=01, pc_load=1. Next prog_addr=023, inst=000, flush=1; the following cycle fetches from 023.
- CALL/RETLW: at pc=011, CALL 9F0 with pa=00 gives prog_addr=0F0 and stack[0]=011. RETLW pop gives prog_addr=011 with a bubble.
- Stack overflow: three CALLs from return addresses 005, 00A, 00F, then two pops return 00F then 00A. A third pop returns 00A again (underflow).
- Skip: inst_skip=1 and skip_cond=1 give a PC increment and inst=000 the next cycle. skip_cond=0 gives no bubble.
- PCL write and wrap: pc_wen with data_in=3C and pa=10 gives prog_addr=43C. From pc=7FF with no branch, the next PC is 000.
